// File: rtl/addsub_pkg.sv
// Shared types and constants for the nibble-serial add/subtract unit.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_DEF  = 16;
  localparam int NIBBLE_DEF = 4;

  // Saturation targets at the default width.
  localparam logic [WIDTH_DEF-1:0] SAT_SMAX = 16'h7FFF;
  localparam logic [WIDTH_DEF-1:0] SAT_SMIN = 16'h8000;
  localparam logic [WIDTH_DEF-1:0] SAT_UMAX = 16'hFFFF;
  localparam logic [WIDTH_DEF-1:0] SAT_ZERO = 16'h0000;

endpackage

// File: rtl/nibble_adder.sv
// NIBBLE-bit ripple adder; also exposes the carry into its top bit for overflow detection.
module nibble_adder #(
  parameter int NIBBLE = 4
) (
  input  logic [NIBBLE-1:0] a,
  input  logic [NIBBLE-1:0] b,
  input  logic              cin,
  output logic [NIBBLE-1:0] sum,
  output logic              cout,
  output logic              cmsb
);

  logic c;

  always_comb begin
    sum  = '0;
    cmsb = 1'b0;
    c    = cin;
    for (int i = 0; i < NIBBLE; i++) begin
      if (i == NIBBLE - 1) cmsb = c;
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
    end
    cout = c;
  end

endmodule

// File: rtl/nibble_serial_addsub.sv
// Nibble-serial WIDTH-bit add/subtract with valid/ready on both sides.
// Optional build macro NIBBLE_ADDSUB_SAT_EN saturates the result when flag is set.
module nibble_serial_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int NIBBLE = NIBBLE_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             flag
);

  localparam int NNIB  = WIDTH / NIBBLE;
  localparam int CNT_W = (NNIB > 1) ? $clog2(NNIB) : 1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic             sub_q, sub_d, sign_q, sign_d;
  logic             cy_q, cy_d, carry_q, carry_d, flag_q, flag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [NIBBLE-1:0] nib_a, nib_b, nib_s;
  logic              nib_co, nib_cm;
  logic              last, ovf;

`ifdef NIBBLE_ADDSUB_SAT_EN
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  function automatic logic [WIDTH-1:0] sat_value(input logic signed_mode,
                                                  input logic sub_op,
                                                  input logic a_msb);
    if (signed_mode) return a_msb ? SMIN : SMAX;
    return sub_op ? '0 : '1;
  endfunction
`endif

  nibble_adder #(.NIBBLE(NIBBLE)) u_nibble_adder (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (cy_q),
    .sum  (nib_s),
    .cout (nib_co),
    .cmsb (nib_cm)
  );

  always_comb begin
    nib_a = a_q[int'(cnt_q)*NIBBLE +: NIBBLE];
    nib_b = b_q[int'(cnt_q)*NIBBLE +: NIBBLE];
    last  = (cnt_q == CNT_W'(NNIB - 1));
    // Only meaningful on the final nibble, where nib_cm is the carry into the word MSB.
    ovf   = sign_q ? (nib_cm ^ nib_co) : (sub_q ? ~nib_co : nib_co);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sub_d   = sub_q;
    sign_d  = sign_q;
    cy_d    = cy_q;
    carry_d = carry_q;
    flag_d  = flag_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          sub_d   = sub;
          sign_d  = sign;
          cy_d    = sub;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d[int'(cnt_q)*NIBBLE +: NIBBLE] = nib_s;
        cy_d  = nib_co;
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          carry_d = nib_co;
          flag_d  = ovf;
`ifdef NIBBLE_ADDSUB_SAT_EN
          if (ovf) res_d = sat_value(sign_q, sub_q, a_q[WIDTH-1]);
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      res_q   <= '0;
      cy_q    <= 1'b0;
      carry_q <= 1'b0;
      flag_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      cy_q    <= cy_d;
      carry_q <= carry_d;
      flag_q  <= flag_d;
      cnt_q   <= cnt_d;
    end
  end

  // Operand registers carry no control meaning, so they are left out of reset.
  always_ff @(posedge clk) begin
    a_q    <= a_d;
    b_q    <= b_d;
    sub_q  <= sub_d;
    sign_q <= sign_d;
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = res_q;
  assign carry     = carry_q;
  assign flag      = flag_q;

endmodule
